// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: PC-select codes, fetch
// state encoding and default widths.
package instr_fetch_unit_pkg;

    localparam int INSTR_W_DEF = 36;
    localparam int ADDR_W_DEF  = 8;

    // Same encoding the control FSM drives on its PC mux select
    localparam logic [1:0] PC_HOLD = 2'b00;
    localparam logic [1:0] PC_INC  = 2'b01;
    localparam logic [1:0] PC_JMP  = 2'b10;
    localparam logic [1:0] PC_HALT = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_IDLE  = 2'b01,
        ST_FETCH = 2'b10,
        ST_HALT  = 2'b11
    } fetch_state_e;

    function automatic logic state_is_busy(input fetch_state_e st);
        return (st == ST_BOOT) || (st == ST_FETCH);
    endfunction

endpackage

// File: rtl/instr_fetch_unit_timer.sv
// Fetch watchdog: loadable/clearable up-counter whose terminal-count flag marks
// the last cycle a memory request may still be acknowledged.
module fetch_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    // tc is raised while the TIMEOUT-th request cycle is in progress
    localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count_r;

    // Counter register: clear has priority over load, load over increment
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (clr) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_val;
        end else if (en) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = (count_r == TC_VAL);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, applies the control FSM's PC-select on
// each fetch request and fetches from instruction memory over req/ack.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fetch_req,
    input  logic [1:0]         pc_sel,
    input  logic [ADDR_W-1:0]  jmp_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instruction,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted,
    output logic               fetch_err
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam int                TMR_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    fetch_state_e       state_r, state_s;
    logic [ADDR_W-1:0]  pc_r, pc_s, addr_r, addr_s, next_pc_s;
    logic [INSTR_W-1:0] instr_r, instr_s;
    logic               valid_r, valid_s;
    logic               req_r, req_s;
    logic               halted_r, halted_s;
    logic               err_r, err_s;
    logic               busy_r, busy_s;
    logic               tmr_clr_s, tmr_en_s, tmr_tc_s;

    fetch_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmr_clr_s),
        .load     (1'b0),
        .load_val ({TMR_W{1'b0}}),
        .en       (tmr_en_s),
        .tc       (tmr_tc_s)
    );

    // PC mux driven by the control FSM's select code
    always_comb begin
        next_pc_s = pc_r;
        case (pc_sel)
            PC_INC:  next_pc_s = pc_r + PC_ONE;
            PC_JMP:  next_pc_s = jmp_target;
            default: next_pc_s = pc_r;
        endcase
    end

    // Next-state and next-register values for the fetch FSM
    always_comb begin
        state_s   = state_r;
        pc_s      = pc_r;
        addr_s    = addr_r;
        instr_s   = instr_r;
        valid_s   = 1'b0;
        req_s     = req_r;
        halted_s  = halted_r;
        err_s     = err_r;
        tmr_clr_s = 1'b0;
        tmr_en_s  = 1'b0;
        case (state_r)
            ST_BOOT: begin
                req_s     = 1'b1;
                addr_s    = RESET_PC;
                tmr_clr_s = 1'b1;
                state_s   = ST_FETCH;
                if (fetch_req) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
            end
            ST_IDLE: begin
                if (fetch_req && (pc_sel == PC_HALT)) begin
                    halted_s = 1'b1;
                    req_s    = 1'b0;
                    state_s  = ST_HALT;
                end else if (fetch_req) begin
                    pc_s      = next_pc_s;
                    addr_s    = next_pc_s;
                    req_s     = 1'b1;
                    tmr_clr_s = 1'b1;
                    state_s   = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (fetch_req) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                // An ack on the timeout cycle still completes the fetch
                if (imem_ack) begin
                    instr_s   = imem_rdata;
                    valid_s   = 1'b1;
                    req_s     = 1'b0;
                    tmr_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else if (tmr_tc_s) begin
                    req_s     = 1'b0;
                    err_s     = 1'b1;
                    tmr_clr_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    tmr_en_s = 1'b1;
                end
            end
            ST_HALT: begin
                req_s   = 1'b0;
                state_s = ST_HALT;
            end
            default: begin
                req_s   = 1'b0;
                state_s = ST_BOOT;
            end
        endcase
        busy_s = state_is_busy(state_s);
    end

    // State and output registers; reset abandons any in-flight fetch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC;
            addr_r   <= RESET_PC;
            instr_r  <= '0;
            valid_r  <= 1'b0;
            req_r    <= 1'b0;
            halted_r <= 1'b0;
            err_r    <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            addr_r   <= addr_s;
            instr_r  <= instr_s;
            valid_r  <= valid_s;
            req_r    <= req_s;
            halted_r <= halted_s;
            err_r    <= err_s;
            busy_r   <= busy_s;
        end
    end

    assign pc          = pc_r;
    assign imem_addr   = addr_r;
    assign imem_req    = req_r;
    assign instruction = instr_r;
    assign instr_valid = valid_r;
    assign busy        = busy_r;
    assign halted      = halted_r;
    assign fetch_err   = err_r;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Supplies the instruction word to the processor control FSM and owns the program counter.
- Applies the control FSM's PC-select code (hold / increment / jump / halt) on each fetch request.
- Fetches from instruction memory over a req/ack handshake and presents the latched instruction with a one-cycle valid strobe.
- Sits between the control unit and instruction memory.

Parameters:
- ADDR_W, 8, width of PC and instruction-memory address.
- INSTR_W, 36, instruction word width.
- RESET_PC, 0, PC value after reset; also the boot-fetch address.
- TIMEOUT, 15, max cycles to wait for imem_ack before aborting a fetch (≥1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- fetch_req  in  1  control FSM requests the next instruction (single-cycle pulse).
- pc_sel  in  2  00 hold, 01 PC+1, 10 jump to jmp_target, 11 halt; sampled only with an accepted fetch_req.
- jmp_target  in  ADDR_W  jump destination (instruction field).
- imem_req  out  1  memory request; held until ack or timeout.
- imem_addr  out  ADDR_W  memory address; stable while imem_req=1.
- imem_ack  in  1  memory acknowledge; imem_rdata valid in the same cycle.
- imem_rdata  in  INSTR_W  memory read data.
- instruction  out  INSTR_W  instruction register.
- instr_valid  out  1  one-cycle pulse when instruction is updated.
- pc  out  ADDR_W  current PC.
- busy  out  1  high in BOOT and FETCH.
- halted  out  1  sticky; set by halt.
- fetch_err  out  1  sticky; set by timeout or by a fetch_req arriving while busy.

Behaviour:
- Synchronous reset (rst_n=0 at a posedge):
  - pc=RESET_PC, imem_addr=RESET_PC, instruction=0.
  - instr_valid=0, imem_req=0, halted=0, fetch_err=0, busy=0, timer=0.
  - State goes to BOOT. Reset overrides any in-flight fetch; a late imem_ack is ignored.
- States: BOOT, IDLE, FETCH, HALT.
- BOOT: lasts one cycle. Sets imem_req=1 and imem_addr=RESET_PC, then goes to FETCH. The PC is unchanged.
- IDLE, fetch_req=1 (busy=0 in IDLE):
  - pc_sel 01: next = pc+1, wrapping modulo 2^ADDR_W (all-ones → 0).
  - pc_sel 10: next = jmp_target.
  - pc_sel 00: next = pc (refetch).
  - For 00/01/10: pc<=next, imem_addr<=next, imem_req<=1, go to FETCH. imem_req therefore rises the cycle after fetch_req.
  - pc_sel 11: halted<=1, go to HALT, no memory request.
- IDLE, fetch_req=0: hold all state; pc_sel and jmp_target are ignored.
- FETCH:
  - imem_req stays high and imem_addr is stable; the timer increments each cycle.
  - On imem_ack=1: instruction<=imem_rdata, instr_valid<=1 for exactly one cycle, imem_req<=0, timer<=0, go to IDLE.
  - If the timer reaches TIMEOUT without ack: imem_req<=0, fetch_err<=1, instruction unchanged, no instr_valid, go to IDLE. The pc keeps the failed address.
  - Ack and timeout in the same cycle: the ack wins.
  - fetch_req during BOOT or FETCH is dropped and sets fetch_err; the in-flight fetch continues unaffected.
- HALT: terminal. All inputs are ignored, imem_req=0, busy=0. Only reset exits.
- Latency:
  - fetch_req at cycle N → imem_req at N+1.
  - Ack at cycle M ≥ N+1 → instruction/instr_valid visible at M+1.
  - Zero-wait memory (ack in the first req cycle) gives 2 cycles from fetch_req to instr_valid.
- imem_ack outside FETCH is ignored.

Decomposition:
- Shared package holds:
  - PC_SEL codes (PC_HOLD=2'b00, PC_INC=2'b01, PC_JMP=2'b10, PC_HALT=2'b11). These are the same encoding the control FSM drives on its PC mux select.
  - Fetch state encoding.
  - INSTR_W default.
- One sub-module: fetch_timer. It is a loadable/clearable counter with a terminal-count flag at TIMEOUT, instantiated once.

Test Plan:
- Reset then zero-wait memory returning 36'h0_0000_0042 at addr 0 → imem_req at cycle 1 after reset deassert, instr_valid pulse, instruction=36'h42, pc=0, busy=0.
- pc=5, fetch_req with pc_sel=01, ack after 3 wait cycles → imem_addr=6 held constant 3 cycles, instr_valid exactly 1 cycle after ack, pc=6.
- pc=8'hFF, pc_sel=01 → imem_addr=8'h00, pc=0 (wrap). Then pc_sel=10, jmp_target=8'h3A → imem_addr=8'h3A.
- No ack for 15 cycles → imem_req drops, fetch_err=1, no instr_valid, instruction unchanged. Ack and timeout in the same cycle → instruction captured, fetch_err stays 0.
- pc_sel=11 with fetch_req → halted=1, imem_req never asserts. A later fetch_req and imem_ack cause no change until rst_n=0.
- fetch_req pulsed mid-FETCH → fetch_err=1, original address completes normally. rst_n=0 mid-FETCH → imem_req=0 next cycle, then BOOT refetches RESET_PC.
